// File: rtl/pipe_vr_pkg.sv
// Shared constants and sizing helpers for the valid/ready pipeline stages.
package pipe_vr_pkg;

    localparam int PIPE_VR_MAX_STAGES = 8;

    // Skid storage needed to absorb every beat granted while ready is in flight.
    function automatic int skid_depth(input int stages);
        return 2 * stages;
    endfunction

    // Bits needed to count 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vr_skid_fifo.sv
// Circular skid buffer with registered valid and storage-driven read data.
// Optional checks: define REV_PIPE_VR_ASSERT_EN to compile in SVA.
module vr_skid_fifo
    import pipe_vr_pkg::*;
#(
    parameter int unsigned  P_DATA_WIDTH = 32,
    parameter int unsigned  P_DEPTH      = 2,
    localparam int unsigned OCC_W        = unsigned'(occ_width(int'(P_DEPTH)))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [P_DATA_WIDTH-1:0] wr_data,
    input  logic                    ready_out,
    output logic                    valid_out,
    output logic [P_DATA_WIDTH-1:0] data_out,
    output logic [OCC_W-1:0]        occ_next_c
);

    localparam int unsigned PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int unsigned LAST  = P_DEPTH - 1;

    logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]        wp;
    logic [PTR_W-1:0]        rp;
    logic [OCC_W-1:0]        occ;
    logic                    valid_q;
    logic                    pop;

    assign pop       = valid_q && ready_out;
    assign valid_out = valid_q;
    assign data_out  = mem[rp];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        occ_next_c = occ;
        case ({push, pop})
            2'b10:   occ_next_c = occ + OCC_W'(1);
            2'b01:   occ_next_c = occ - OCC_W'(1);
            default: occ_next_c = occ;
        endcase
    end

    // Payload storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_data;
        end
    end

    // Pointers, occupancy and output valid, wrapping at a non-power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            occ     <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                wp <= (wp == PTR_W'(LAST)) ? '0 : wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= (rp == PTR_W'(LAST)) ? '0 : rp + PTR_W'(1);
            end
            occ     <= occ_next_c;
            valid_q <= (occ_next_c != '0);
        end
    end

`ifdef REV_PIPE_VR_ASSERT_EN
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (occ == OCC_W'(P_DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (occ == '0)));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_q && !ready_out) |=> (valid_q && $stable(data_out)));

    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        occ <= OCC_W'(P_DEPTH));
`endif

endmodule

// File: rtl/rev_pipe_vr.sv
// Reverse (ready-path) pipeline stage: ready is retimed through P_STAGES flops
// and a 2*P_STAGES skid buffer absorbs beats granted while ready is in flight.
// Optional checks: define REV_PIPE_VR_ASSERT_EN to compile in SVA.
module rev_pipe_vr
    import pipe_vr_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_STAGES     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [P_DATA_WIDTH-1:0] data_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [P_DATA_WIDTH-1:0] data_out,
    input  logic                    ready_out
);

    localparam int unsigned DEPTH      = unsigned'(skid_depth(int'(P_STAGES)));
    localparam int unsigned OCC_W      = unsigned'(occ_width(int'(DEPTH)));
    localparam int unsigned RDY_THRESH = DEPTH - P_STAGES;

    logic [P_STAGES-1:0] rdy;
    logic                push;
    logic [OCC_W-1:0]    occ_next_c;

    assign push     = valid_in && ready_in;
    assign ready_in = rdy[P_STAGES-1];

    vr_skid_fifo #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .wr_data    (data_in),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .occ_next_c (occ_next_c)
    );

    // Grant only while room remains for every beat accepted under grants in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy <= '0;
        end else begin
            rdy[0] <= (occ_next_c <= OCC_W'(RDY_THRESH));
            for (int i = 1; i < int'(P_STAGES); i++) begin
                rdy[i] <= rdy[i-1];
            end
        end
    end

`ifdef REV_PIPE_VR_ASSERT_EN
    if ((P_STAGES < 1) || (P_STAGES > PIPE_VR_MAX_STAGES)) begin : g_bad_stages
        $error("rev_pipe_vr: P_STAGES out of range 1..%0d", PIPE_VR_MAX_STAGES);
    end
`endif

endmodule

// File: tb/tb_rev_pipe_vr.sv
// Directed self-checking bench for rev_pipe_vr (P_STAGES=3, skid depth 6).
module tb_rev_pipe_vr;

    localparam int unsigned DW     = 8;
    localparam int unsigned STAGES = 3;
    localparam int unsigned DEPTH  = 6;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ready_out;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    rev_pipe_vr #(
        .P_DATA_WIDTH (DW),
        .P_STAGES     (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reset holds outputs low; ready_in rises exactly STAGES edges after release.
    task automatic test_reset();
        logic exp_r;
        rst = 1'b1; valid_in = 1'b1; data_in = 8'h11; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_in !== 1'b0) begin errors++; $display("FAIL reset_ready_in got %b exp 0", ready_in); end
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_r = (k >= 3);
            checks++;
            if (ready_in !== exp_r) begin errors++; $display("FAIL release_ready_in edge %0d got %b exp %b", k, ready_in, exp_r); end
            exp_r = (k >= 4);
            checks++;
            if (valid_out !== exp_r) begin errors++; $display("FAIL release_valid_out edge %0d got %b exp %b", k, valid_out, exp_r); end
            if (k == 4) begin
                checks++;
                if (data_out !== 8'h11) begin errors++; $display("FAIL release_first_data got %h exp 11", data_out); end
            end
        end
        valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL release_drain got %b exp 0", valid_out); end
        @(posedge clk); #1;
    endtask

    // 64 back-to-back beats, each out one cycle after its input.
    task automatic test_streaming();
        logic exp_v;
        ready_out = 1'b1;
        for (int c = 0; c <= 65; c++) begin
            valid_in = (c < 64);
            data_in  = 8'(c);
            @(negedge clk);
            exp_v = (c >= 1) && (c <= 64);
            checks++;
            if (ready_in !== 1'b1) begin errors++; $display("FAIL stream_ready_in cycle %0d got %b exp 1", c, ready_in); end
            checks++;
            if (valid_out !== exp_v) begin errors++; $display("FAIL stream_valid cycle %0d got %b exp %b", c, valid_out, exp_v); end
            if (exp_v) begin
                checks++;
                if (data_out !== 8'(c - 1)) begin errors++; $display("FAIL stream_data cycle %0d got %h exp %h", c, data_out, 8'(c - 1)); end
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    // Continuous stream with a 20-cycle downstream stall; ready_in timeline is hand-derived.
    task automatic test_stall();
        logic [DW-1:0] nxt;
        logic [DW-1:0] stall_data;
        logic [DW-1:0] exp_d;
        logic          exp_r;
        nxt = 8'h40;
        stall_data = '0;
        exp_q.delete();
        for (int t = 0; t < 50; t++) begin
            ready_out = !((t >= 10) && (t <= 29));
            valid_in  = 1'b1;
            data_in   = nxt;
            @(negedge clk);
            exp_r = !((t >= 15) && (t <= 34));
            checks++;
            if (ready_in !== exp_r) begin errors++; $display("FAIL stall_ready_in cycle %0d got %b exp %b", t, ready_in, exp_r); end
            if (t == 10) stall_data = data_out;
            if ((t >= 11) && (t <= 29)) begin
                checks++;
                if ((valid_out !== 1'b1) || (data_out !== stall_data)) begin
                    errors++; $display("FAIL stall_hold cycle %0d got v=%b d=%h exp v=1 d=%h", t, valid_out, data_out, stall_data);
                end
            end
            if (valid_out && ready_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_spurious cycle %0d got %h exp none", t, data_out);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (data_out !== exp_d) begin errors++; $display("FAIL stall_order cycle %0d got %h exp %h", t, data_out, exp_d); end
                end
            end
            if (valid_in && ready_in) begin
                exp_q.push_back(data_in);
                nxt = nxt + 8'd1;
            end
            checks++;
            if (exp_q.size() > DEPTH) begin errors++; $display("FAIL stall_capacity cycle %0d got %0d exp <=%0d", t, exp_q.size(), DEPTH); end
            @(posedge clk); #1;
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int t = 0; (t < 20) && (exp_q.size() != 0); t++) begin
            @(negedge clk);
            if (valid_out) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (data_out !== exp_d) begin errors++; $display("FAIL stall_drain got %h exp %h", data_out, exp_d); end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain_timeout left %0d exp 0", exp_q.size()); end
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL stall_empty got %b exp 0", valid_out); end
        @(posedge clk); #1;
    endtask

    // Random valid/ready at 50%: scoreboard order and stall stability.
    task automatic test_random();
        int            sent;
        int            got;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] exp_d;
        sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
        exp_q.delete();
        for (int cyc = 0; (cyc < 20000) && (got < 2000); cyc++) begin
            valid_in  = (sent < 2000) && ($urandom_range(0, 1) == 1);
            data_in   = 8'($urandom);
            ready_out = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if ((valid_out !== 1'b1) || (data_out !== prev_data)) begin
                    errors++; $display("FAIL rand_stable cycle %0d got v=%b d=%h exp v=1 d=%h", cyc, valid_out, data_out, prev_data);
                end
            end
            prev_stall = valid_out && !ready_out;
            prev_data  = data_out;
            if (valid_out && ready_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious cycle %0d got %h exp none", cyc, data_out);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (data_out !== exp_d) begin errors++; $display("FAIL rand_order cycle %0d got %h exp %h", cyc, data_out, exp_d); end
                end
                got++;
            end
            if (valid_in && ready_in) begin
                exp_q.push_back(data_in);
                sent++;
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        checks++;
        if (got != 2000) begin errors++; $display("FAIL rand_count got %0d exp 2000", got); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d exp 0", exp_q.size()); end
    endtask

    // Reset with three stored beats discards them; 0xA5 is the first beat afterwards.
    task automatic test_mid_reset();
        int            acc;
        int            popped;
        logic [DW-1:0] exp_d;
        acc = 0;
        ready_out = 1'b0;
        for (int t = 0; (t < 20) && (acc < 3); t++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'hC0 + acc);
            @(negedge clk);
            if (valid_in && ready_in) acc++;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if ((acc != 3) || (valid_out !== 1'b1)) begin errors++; $display("FAIL mrst_fill got acc=%0d v=%b exp acc=3 v=1", acc, valid_out); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_out = 1'b1;
        exp_q.delete();
        acc = 0; popped = 0;
        for (int t = 0; t < 30; t++) begin
            valid_in = (acc < 2);
            data_in  = (acc == 0) ? 8'hA5 : 8'h5A;
            @(negedge clk);
            if (t == 0) begin
                checks++;
                if (valid_out !== 1'b0) begin errors++; $display("FAIL mrst_valid_after_reset got %b exp 0", valid_out); end
            end
            if (valid_out && ready_out) begin
                checks++;
                if (popped == 0) begin
                    if (data_out !== 8'hA5) begin errors++; $display("FAIL mrst_first_beat got %h exp a5", data_out); end
                end else if (exp_q.size() == 0) begin
                    errors++; $display("FAIL mrst_spurious got %h exp none", data_out);
                end
                if (exp_q.size() != 0) begin
                    exp_d = exp_q.pop_front();
                    checks++;
                    if (data_out !== exp_d) begin errors++; $display("FAIL mrst_order got %h exp %h", data_out, exp_d); end
                end
                popped++;
            end
            if (valid_in && ready_in) begin
                exp_q.push_back(data_in);
                acc++;
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        checks++;
        if (popped != 2) begin errors++; $display("FAIL mrst_count got %0d exp 2", popped); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
